// File: rtl/pkt_tx_scheduler.sv
// Packet scheduler between the byte FIFO read side and the UART transmitter.
// Frames each packet as SOF, LEN, payload bytes, CHK (XOR of LEN and payload).
module pkt_tx_scheduler #(
    parameter int          PTR_WIDTH   = 4,
    parameter int          MAX_PAYLOAD = 8,
    parameter int          TIMEOUT     = 64,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_wr_en,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_dout,
    input  logic                 fifo_dout_valid,
    output logic                 fifo_rd_en,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 pkt_busy,
    output logic                 pkt_done,
    output logic [PTR_WIDTH:0]   occupancy
);

    localparam int OCC_W = PTR_WIDTH + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [OCC_W-1:0] DEPTH = OCC_W'(1 << PTR_WIDTH);
    localparam logic [OCC_W-1:0] MAX_P = OCC_W'(MAX_PAYLOAD);
    localparam logic [TMR_W-1:0] TMO   = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_LEN, S_RD, S_WAIT, S_PAY, S_CHK
    } state_t;

    state_t             state, state_next;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   len;
    logic [OCC_W-1:0]   remaining;
    logic [OCC_W-1:0]   pkt_len;
    logic [TMR_W-1:0]   timer;
    logic [7:0]         chk;
    logic [7:0]         pay_byte;
    logic               push_acc;
    logic               pop_acc;
    logic               trigger;

    assign occupancy = occ;
    assign push_acc  = fifo_wr_en && !fifo_full;
    assign pop_acc   = fifo_rd_en && !fifo_empty;
    assign trigger   = (occ >= MAX_P) || ((occ != '0) && (timer == TMO));
    assign pkt_len   = (occ >= MAX_P) ? MAX_P : occ;

    // tx_valid/tx_data are decoded from state alone, so they cannot change
    // while a byte is waiting for tx_ready.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        pkt_done   = 1'b0;
        pkt_busy   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (trigger) state_next = S_SOF;
            end
            S_SOF: begin
                tx_valid = 1'b1;
                tx_data  = SOF_BYTE;
                if (tx_ready) state_next = S_LEN;
            end
            S_LEN: begin
                tx_valid = 1'b1;
                tx_data  = 8'(len);
                if (tx_ready) state_next = S_RD;
            end
            S_RD: begin
                fifo_rd_en = !fifo_empty;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_dout_valid) state_next = S_PAY;
            end
            S_PAY: begin
                tx_valid = 1'b1;
                tx_data  = pay_byte;
                if (tx_ready) state_next = (remaining != '0) ? S_RD : S_CHK;
            end
            S_CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk;
                if (tx_ready) begin
                    pkt_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            occ       <= '0;
            timer     <= '0;
            len       <= '0;
            remaining <= '0;
            chk       <= '0;
            pay_byte  <= '0;
        end else begin
            state <= state_next;

            if (push_acc && !pop_acc && occ != DEPTH)
                occ <= occ + OCC_W'(1);
            else if (pop_acc && !push_acc && occ != '0)
                occ <= occ - OCC_W'(1);

            if (push_acc || occ == '0)
                timer <= '0;
            else if (state == S_IDLE && timer != TMO)
                timer <= timer + TMR_W'(1);

            // len is frozen at trigger; later pushes wait for the next packet.
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        len <= pkt_len;
                        chk <= 8'(pkt_len);
                    end
                end
                S_LEN: begin
                    if (tx_ready) remaining <= len;
                end
                S_WAIT: begin
                    if (fifo_dout_valid) begin
                        pay_byte  <= fifo_dout;
                        chk       <= chk ^ fifo_dout;
                        remaining <= remaining - OCC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pkt_tx_scheduler.md
Name: pkt_tx_scheduler

Overview:
- Controller between the byte FIFO and the UART transmitter. It tracks FIFO occupancy, decides when a packet is due (payload limit reached, or idle timeout), and pops the FIFO one byte at a time.
- It emits each packet to the UART TX as a framed sequence: SOF, LEN, payload bytes, CHK.
- It owns the FIFO read side exclusively.

Parameters:
- PTR_WIDTH, 4, FIFO pointer width. FIFO depth is 2**PTR_WIDTH; the occupancy counter is PTR_WIDTH+1 bits.
- MAX_PAYLOAD, 8, maximum payload bytes per packet. Legal range 1..2**PTR_WIDTH.
- TIMEOUT, 64, idle cycles with no push before a partial packet is flushed. Must be ≥1.
- SOF_BYTE, 8'hA5, start-of-frame byte.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- fifo_wr_en, input, 1: the FIFO write strobe, observed for occupancy tracking.
- fifo_full, input, 1: FIFO full flag.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_dout, input, 8: FIFO read data.
- fifo_dout_valid, input, 1: FIFO read data valid, one cycle after an accepted read.
- fifo_rd_en, output, 1: FIFO pop request.
- tx_data, output, 8: byte to the UART TX.
- tx_valid, output, 1: tx_data valid.
- tx_ready, input, 1: UART TX accepts a byte when tx_valid && tx_ready.
- pkt_busy, output, 1: high from packet start until CHK is accepted.
- pkt_done, output, 1: one-cycle pulse when CHK is accepted.
- occupancy, output, PTR_WIDTH+1: tracked FIFO byte count.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; occupancy=0; timer=0; len=0; chk=0.
  - Outputs: fifo_rd_en=0, tx_valid=0, tx_data=0, pkt_busy=0, pkt_done=0.
  - Reset mid-packet abandons the packet with no CHK emitted.
  - The FIFO must be reset on the same cycle; the integration requirement is one shared reset.
- Occupancy, every cycle:
  - +1 when fifo_wr_en && !fifo_full.
  - −1 when fifo_rd_en && !fifo_empty.
  - Both in the same cycle: unchanged.
  - Never wraps: saturates at 0 and at 2**PTR_WIDTH.
- Timer:
  - Cleared on any accepted push, or when occupancy==0.
  - Otherwise increments in IDLE, saturating at TIMEOUT.
- Trigger, evaluated in IDLE only:
  - Fires when occupancy ≥ MAX_PAYLOAD, or when occupancy>0 && timer==TIMEOUT.
  - On trigger, latch len = min(occupancy, MAX_PAYLOAD), set chk = len, and go to SOF.
  - Pushes arriving during a packet are counted but are not added to the current len.
- tx_valid/tx_data rules:
  - Once tx_valid is asserted, it and tx_data stay stable until tx_ready is sampled high.
  - A transfer completes on the edge where tx_valid && tx_ready.
  - At most one byte is transferred per cycle.
- States:
  - IDLE: tx_valid=0, pkt_busy=0.
  - SOF: tx_data=SOF_BYTE, tx_valid=1. On transfer, go to LEN.
  - LEN: tx_data=len. On transfer, set remaining=len and go to RD.
  - RD: assert fifo_rd_en for exactly one cycle, deassert tx_valid, go to WAIT.
  - WAIT: on fifo_dout_valid, load tx_data=fifo_dout, set chk ^= fifo_dout, decrement remaining, go to PAY. Occupancy>0 guarantees the data arrives the next cycle.
  - PAY: tx_valid=1. On transfer, go to RD if remaining>0, else go to CHK.
  - CHK: tx_data=chk (XOR of LEN and all payload bytes), tx_valid=1. On transfer, pulse pkt_done and go to IDLE. The trigger is re-evaluated from the following cycle.
- pkt_busy=1 in every state except IDLE.
- fifo_rd_en is never asserted outside RD and never while fifo_empty=1.
- Latency:
  - Trigger to SOF tx_valid: 1 cycle.
  - Per payload byte with tx_ready held at 1: 3 cycles (RD, WAIT, PAY).
  - Minimum packet length: 3+3·len cycles from SOF to pkt_done.
- Back-to-back packets: if occupancy ≥ MAX_PAYLOAD when returning to IDLE, the next SOF is issued after one IDLE cycle.

Test Plan:
- Push 8 bytes 0x01..0x08 (MAX_PAYLOAD=8), tx_ready=1 → TX stream A5,08,01..08,00 (chk=08^01^…^08=0x00); pkt_done one pulse; occupancy ends at 0.
- Push 3 bytes 0x10,0x20,0x30, then idle → no SOF until 64 idle cycles have elapsed; then A5,03,10,20,30,03 (chk=03^10^20^30=0x03).
- Push 16 bytes 0x00..0x0F → two packets: A5,08,00..07,08 then A5,08,08..0F,08 (chk=08^08^…^0F); fifo_rd_en never asserted while fifo_empty=1.
- Hold tx_ready=0 for 5 cycles during LEN and during a payload byte → tx_data/tx_valid stable throughout; no extra FIFO pops; stream contents unchanged.
- Push continuously during a packet, including same-cycle push and pop → occupancy stays exact and never wraps; the in-flight packet keeps its latched len.
- Drive rst_n=0 mid-payload → next cycle state=IDLE, tx_valid=0, occupancy=0, pkt_busy=0; a fresh 8-byte push then yields a complete correct packet.
